// File: rtl/one_cold_pkg.sv
// ---------------------------------------------------------------------------
// one_cold_pkg
// Shared types and helpers for the one-cold / one-hot scan decoder.
//   state_t       : sequencer states (blank, driving a position, blank gap)
//   MODE_AUTO     : mode input value selecting automatic scanning
//   MODE_MANUAL   : mode input value selecting a held, loadable index
//   inactive_vec  : idle level of every select line for a given polarity
// ---------------------------------------------------------------------------
package one_cold_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic MODE_AUTO   = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;

  // Widest supported decoder; callers slice the low N_OUT bits.
  localparam int MAX_OUT = 64;

  // All lines idle: high for one-cold outputs, low for one-hot outputs.
  function automatic logic [MAX_OUT-1:0] inactive_vec(input logic active_low);
    return active_low ? {MAX_OUT{1'b1}} : {MAX_OUT{1'b0}};
  endfunction

endpackage

// File: rtl/one_cold_dec_n.sv
// ---------------------------------------------------------------------------
// one_cold_dec_n
// Combinational index-to-N_OUT decoder with selectable polarity.
// Ports:
//   idx   in  SEL_W   index of the line to activate
//   blank in  1       1 forces every line to its idle level
//   vec   out N_OUT   decoded lines (one-cold if ACTIVE_LOW, else one-hot)
// ---------------------------------------------------------------------------
module one_cold_dec_n
  import one_cold_pkg::*;
#(
  parameter int N_OUT      = 8,
  parameter int ACTIVE_LOW = 1,
  localparam int SEL_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic [SEL_W-1:0] idx,
  input  logic             blank,
  output logic [N_OUT-1:0] vec
);

  localparam logic [MAX_OUT-1:0] IDLE = inactive_vec(ACTIVE_LOW != 0);

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_line
      assign vec[gi] = (!blank && (idx == SEL_W'(gi))) ? ~IDLE[gi] : IDLE[gi];
    end
  endgenerate

endmodule

// File: rtl/one_cold_scan_decoder.sv
// ---------------------------------------------------------------------------
// one_cold_scan_decoder
// Registered one-cold/one-hot select-line decoder with a scan sequencer.
// Auto mode dwells DWELL cycles on each position with GAP blank cycles in
// between; manual mode holds an index loaded through sel_in/sel_load.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   en        in   0 blanks outputs and freezes the sequencer
//   mode      in   0 = auto scan, 1 = manual
//   sel_in    in   index to load in manual mode
//   sel_load  in   single-cycle load strobe (manual mode only)
//   scan_mask in   (only with SCAN_MASK_EN) positions included in auto scan
//   res       out  decoded select lines, registered
//   cur_sel   out  index currently selected, registered
//   active    out  1 while res drives a position
//   wrap      out  one-cycle pulse when the scan passes index N_OUT-1
// Optional build macro: SCAN_MASK_EN adds scan_mask and masked skipping.
// ---------------------------------------------------------------------------
module one_cold_scan_decoder
  import one_cold_pkg::*;
#(
  parameter int N_OUT      = 8,
  parameter int DWELL      = 50000,
  parameter int GAP        = 1,
  parameter int ACTIVE_LOW = 1,
  localparam int SEL_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             sel_load,
`ifdef SCAN_MASK_EN
  input  logic [N_OUT-1:0] scan_mask,
`endif
  output logic [N_OUT-1:0] res,
  output logic [SEL_W-1:0] cur_sel,
  output logic             active,
  output logic             wrap
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int GW_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [MAX_OUT-1:0] IDLE = inactive_vec(ACTIVE_LOW != 0);

  state_t            state_reg, state_next;
  logic [SEL_W-1:0]  cur_sel_reg, sel_next;
  logic [DW_W-1:0]   dwell_cnt_reg, dwell_next;
  logic [GW_W-1:0]   gap_cnt_reg, gap_next;
  logic [N_OUT-1:0]  res_reg, dec_vec;
  logic              active_reg, active_next;
  logic              wrap_reg, wrap_next;

  logic              sel_valid, load_ok, dwell_done, gap_done;
  logic              mask_empty;
  logic [SEL_W-1:0]  adv_idx;
  logic              adv_wrap;

  // Indices beyond N_OUT-1 can only occur for non-power-of-2 N_OUT.
  assign sel_valid  = int'(sel_in) < N_OUT;
  assign load_ok    = (mode == MODE_MANUAL) && sel_load && sel_valid;
  assign dwell_done = int'(dwell_cnt_reg) == DWELL - 1;
  assign gap_done   = (GAP == 0) || (int'(gap_cnt_reg) == GAP - 1);

`ifdef SCAN_MASK_EN
  logic adv_found;
  int   adv_t;

  // Next enabled position after cur_sel, searching cyclically. With a
  // single enabled bit the search lands back on cur_sel itself.
  always_comb begin
    adv_idx   = cur_sel_reg;
    adv_found = 1'b0;
    adv_t     = 0;
    for (int k = 1; k <= N_OUT; k++) begin
      adv_t = int'(cur_sel_reg) + k;
      if (adv_t >= N_OUT) adv_t = adv_t - N_OUT;
      if (!adv_found && scan_mask[adv_t]) begin
        adv_idx   = SEL_W'(adv_t);
        adv_found = 1'b1;
      end
    end
  end

  assign mask_empty = (scan_mask == '0);
`else
  assign adv_idx    = (cur_sel_reg == SEL_W'(N_OUT - 1)) ? '0 : cur_sel_reg + 1'b1;
  assign mask_empty = 1'b0;
`endif

  // Any advance that does not move to a higher index has passed N_OUT-1.
  assign adv_wrap = (adv_idx <= cur_sel_reg);

  always_comb begin
    state_next = state_reg;
    sel_next   = cur_sel_reg;
    dwell_next = dwell_cnt_reg;
    gap_next   = gap_cnt_reg;
    wrap_next  = 1'b0;
    if (!en) begin
      state_next = ST_BLANK;
      dwell_next = '0;
      gap_next   = '0;
    end else begin
      case (state_reg)
        ST_BLANK: begin
          dwell_next = '0;
          gap_next   = '0;
          // A load arriving while blanked only retargets cur_sel; the
          // new position is driven from the following edge.
          if (load_ok)
            sel_next = sel_in;
          else if ((mode == MODE_AUTO) && mask_empty)
            state_next = ST_GAP;
          else
            state_next = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (mode == MODE_MANUAL) begin
            dwell_next = '0;
            if (load_ok) sel_next = sel_in;
          end else if (dwell_done) begin
            dwell_next = '0;
            if ((GAP == 0) && !mask_empty) begin
              sel_next  = adv_idx;
              wrap_next = adv_wrap;
            end else begin
              state_next = ST_GAP;
              gap_next   = '0;
            end
          end else begin
            dwell_next = dwell_cnt_reg + 1'b1;
          end
        end
        ST_GAP: begin
          if (mode == MODE_MANUAL) begin
            // Switching to manual abandons the gap and re-drives cur_sel.
            state_next = ST_DRIVE;
            dwell_next = '0;
            gap_next   = '0;
            if (load_ok) sel_next = sel_in;
          end else if (mask_empty) begin
            state_next = ST_GAP;
          end else if (gap_done) begin
            state_next = ST_DRIVE;
            sel_next   = adv_idx;
            wrap_next  = adv_wrap;
            dwell_next = '0;
            gap_next   = '0;
          end else begin
            gap_next = gap_cnt_reg + 1'b1;
          end
        end
        default: state_next = ST_BLANK;
      endcase
    end
  end

  assign active_next = (state_next == ST_DRIVE);

  // Decode the next-state index so res registers on the same edge as
  // cur_sel and active.
  one_cold_dec_n #(
    .N_OUT      (N_OUT),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .idx   (sel_next),
    .blank (!active_next),
    .vec   (dec_vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_BLANK;
      cur_sel_reg   <= '0;
      dwell_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
      res_reg       <= IDLE[N_OUT-1:0];
      active_reg    <= 1'b0;
      wrap_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_sel_reg   <= sel_next;
      dwell_cnt_reg <= dwell_next;
      gap_cnt_reg   <= gap_next;
      res_reg       <= dec_vec;
      active_reg    <= active_next;
      wrap_reg      <= wrap_next;
    end
  end

  assign res     = res_reg;
  assign cur_sel = cur_sel_reg;
  assign active  = active_reg;
  assign wrap    = wrap_reg;

endmodule
